// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, logic constants and pipe-register reset values.
package cpu_pkg;

  localparam logic ONE  = 1'b1;
  localparam logic ZERO = 1'b0;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_NOR  = 4'h5,
    ALU_SLT  = 4'h6,
    ALU_SLTU = 4'h7,
    ALU_SLL  = 4'h8,
    ALU_SRL  = 4'h9,
    ALU_SRA  = 4'hA,
    ALU_LUI  = 4'hB
  } alu_op_t;

  // Control fields carried into the memory stage; rw/mem_rw are active-low write strobes.
  typedef struct packed {
    logic rw;
    logic mem_rw;
    logic sel_mem;
    logic atomic;
    logic halt;
    logic sc_ok;
  } s4_ctrl_t;

  localparam s4_ctrl_t S4_CTRL_RST = '{
    rw: ONE, mem_rw: ONE, sel_mem: ZERO, atomic: ZERO, halt: ZERO, sc_ok: ZERO
  };

  // A bubble looks exactly like the post-reset control bundle: no writes, no memory access.
  localparam s4_ctrl_t S4_CTRL_BUBBLE = S4_CTRL_RST;

  localparam logic [3:0] BYTE_EN_RST = 4'hF;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX/MEM bundle seen by the execute stage.
interface ex_stage_if #(
  parameter int BITS       = 32,
  parameter int ADDR_LEFT  = 4,
  parameter int OP_BITS    = 4,
  parameter int SHIFT_BITS = 5
);

  logic                  atomic_s3;
  logic                  sel_mem_s3;
  logic                  check_link_s3;
  logic                  mem_rw_s3;
  logic                  rw_s3;
  logic                  load_link_s3;
  logic                  alu_imm_s3;
  logic                  halt_s3;
  logic [ADDR_LEFT:0]    waddr_s3;
  logic [BITS-1:0]       r1_data_s3;
  logic [BITS-1:0]       r2_data_s3;
  logic [BITS-1:0]       sign_ext_imm_s3;
  logic [SHIFT_BITS-1:0] shamt_s3;
  logic [OP_BITS-1:0]    alu_op_s3;
  logic [3:0]            byte_en_s3;

  logic [BITS-1:0]       alu_result_s4;
  logic [BITS-1:0]       store_data_s4;
  logic [ADDR_LEFT:0]    waddr_s4;
  logic                  rw_s4;
  logic                  mem_rw_s4;
  logic                  sel_mem_s4;
  logic                  atomic_s4;
  logic                  halt_s4;
  logic [3:0]            byte_en_s4;
  logic                  sc_ok_s4;
  logic                  link_valid;

  modport master (
    output atomic_s3, sel_mem_s3, check_link_s3, mem_rw_s3, rw_s3, load_link_s3,
           alu_imm_s3, halt_s3, waddr_s3, r1_data_s3, r2_data_s3, sign_ext_imm_s3,
           shamt_s3, alu_op_s3, byte_en_s3,
    input  alu_result_s4, store_data_s4, waddr_s4, rw_s4, mem_rw_s4, sel_mem_s4,
           atomic_s4, halt_s4, byte_en_s4, sc_ok_s4, link_valid
  );

  modport slave (
    input  atomic_s3, sel_mem_s3, check_link_s3, mem_rw_s3, rw_s3, load_link_s3,
           alu_imm_s3, halt_s3, waddr_s3, r1_data_s3, r2_data_s3, sign_ext_imm_s3,
           shamt_s3, alu_op_s3, byte_en_s3,
    output alu_result_s4, store_data_s4, waddr_s4, rw_s4, mem_rw_s4, sel_mem_s4,
           atomic_s4, halt_s4, byte_en_s4, sc_ok_s4, link_valid
  );

endinterface

// File: rtl/ex_stage_alu.sv
// Combinational ALU: arithmetic/logic on (a, b), shifts on r2 by shamt.
module alu
  import cpu_pkg::*;
#(
  parameter int BITS       = 32,
  parameter int OP_BITS    = 4,
  parameter int SHIFT_BITS = 5
) (
  input  logic [BITS-1:0]       a,
  input  logic [BITS-1:0]       b,
  input  logic [BITS-1:0]       r2,
  input  logic [SHIFT_BITS-1:0] shamt,
  input  logic [OP_BITS-1:0]    alu_op,
  output logic [BITS-1:0]       result
);

  always_comb begin
    // NOTE: default first so every path assigns result and no latch is inferred.
    result = '0;
    case (alu_op_t'(alu_op))
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {{(BITS-1){ZERO}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(BITS-1){ZERO}}, a < b};
      ALU_SLL:  result = r2 << shamt;
      ALU_SRL:  result = r2 >> shamt;
      ALU_SRA:  result = $unsigned($signed(r2) >>> shamt);
      ALU_LUI:  result = b << 16;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, LL/SC reservation tracking and the EX/MEM pipe register.
module ex_stage
  import cpu_pkg::*;
#(
  parameter int BITS       = 32,
  parameter int REG_WORDS  = 32,
  parameter int ADDR_LEFT  = $clog2(REG_WORDS) - 1,
  parameter int OP_BITS    = 4,
  parameter int SHIFT_BITS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       flush,
  ex_stage_if.slave  bus
);

  logic [BITS-1:0]  op_b;
  logic [BITS-1:0]  result;
  logic [BITS-3:0]  word;
  logic             advance;
  logic             is_sc;
  logic             is_ll;
  logic             is_store;
  logic             link_hit;
  logic             sc_ok;

  logic             link_valid_q;
  logic [BITS-3:0]  link_addr_q;

  s4_ctrl_t         ctrl_d;
  s4_ctrl_t         ctrl_q;
  logic [BITS-1:0]  alu_result_q;
  logic [BITS-1:0]  store_data_q;
  logic [ADDR_LEFT:0] waddr_q;
  logic [3:0]       byte_en_q;

  assign op_b = bus.alu_imm_s3 ? bus.sign_ext_imm_s3 : bus.r2_data_s3;

  alu #(
    .BITS       (BITS),
    .OP_BITS    (OP_BITS),
    .SHIFT_BITS (SHIFT_BITS)
  ) u_alu (
    .a      (bus.r1_data_s3),
    .b      (op_b),
    .r2     (bus.r2_data_s3),
    .shamt  (bus.shamt_s3),
    .alu_op (bus.alu_op_s3),
    .result (result)
  );

  assign word    = result[BITS-1:2];
  assign advance = !stall && !flush;

  // SC outranks LL when both are flagged; load_link_s3 is active-low.
  assign is_sc    = bus.check_link_s3;
  assign is_ll    = !is_sc && bus.sel_mem_s3 && !bus.load_link_s3;
  assign is_store = !is_sc && !bus.mem_rw_s3;
  assign link_hit = (link_addr_q == word);
  assign sc_ok    = is_sc && link_valid_q && link_hit;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      link_valid_q <= ZERO;
      link_addr_q  <= '0;
    end else if (advance) begin
      if (is_sc) begin
        link_valid_q <= ZERO;
      end else if (is_ll) begin
        link_valid_q <= ONE;
        link_addr_q  <= word;
      end else if (is_store && link_hit) begin
        link_valid_q <= ZERO;
      end
    end
  end

  always_comb begin
    ctrl_d.rw      = bus.rw_s3;
    ctrl_d.mem_rw  = bus.mem_rw_s3 | (is_sc & ~sc_ok);  // failed SC must not write memory
    ctrl_d.sel_mem = bus.sel_mem_s3;
    ctrl_d.atomic  = bus.atomic_s3;
    ctrl_d.halt    = bus.halt_s3;
    ctrl_d.sc_ok   = sc_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q       <= S4_CTRL_RST;
      byte_en_q    <= BYTE_EN_RST;
      alu_result_q <= '0;
      store_data_q <= '0;
      waddr_q      <= '0;
    end else if (flush) begin
      ctrl_q <= S4_CTRL_BUBBLE;
    end else if (!stall) begin
      ctrl_q       <= ctrl_d;
      byte_en_q    <= bus.byte_en_s3;
      alu_result_q <= result;
      store_data_q <= bus.r2_data_s3;
      waddr_q      <= bus.waddr_s3;
    end
  end

  assign bus.alu_result_s4 = alu_result_q;
  assign bus.store_data_s4 = store_data_q;
  assign bus.waddr_s4      = waddr_q;
  assign bus.rw_s4         = ctrl_q.rw;
  assign bus.mem_rw_s4     = ctrl_q.mem_rw;
  assign bus.sel_mem_s4    = ctrl_q.sel_mem;
  assign bus.atomic_s4     = ctrl_q.atomic;
  assign bus.halt_s4       = ctrl_q.halt;
  assign bus.sc_ok_s4      = ctrl_q.sc_ok;
  assign bus.byte_en_s4    = byte_en_q;
  assign bus.link_valid    = link_valid_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed and randomized checks of ex_stage against a rule-level reference model.
module tb_ex_stage;

  logic clk = 1'b0;
  logic rst, stall, flush;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ex_stage_if bus ();

  ex_stage dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  // Reference model of what *_s4 and the reservation should hold.
  logic        m_rw, m_mem_rw, m_sel_mem, m_atomic, m_halt, m_sc_ok;
  logic [3:0]  m_be;
  logic [31:0] m_res, m_sd;
  logic [4:0]  m_wa;
  bit          m_dp_ok;
  bit          m_lv;
  logic [29:0] m_la;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] r2, input int sh);
    logic [31:0] fill;
    case (op)
      0:  return a + b;
      1:  return a + (~b) + 32'd1;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ~a & ~b;
      6:  return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
      7:  return {31'd0, a < b};
      8:  return r2 << sh;
      9:  return r2 >> sh;
      10: begin
        fill = r2[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
        return (r2 >> sh) | fill;
      end
      11: return {b[15:0], 16'h0000};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] b, res;
    bit sc, ok, ll, st;
    if (rst) begin
      {m_rw, m_mem_rw, m_sel_mem, m_atomic, m_halt, m_sc_ok} = 6'b110000;
      m_be = 4'hF; m_res = 0; m_sd = 0; m_wa = 0; m_dp_ok = 1; m_lv = 0; m_la = 0;
    end else if (flush) begin
      {m_rw, m_mem_rw, m_sel_mem, m_atomic, m_halt, m_sc_ok} = 6'b110000;
      m_dp_ok = 0;
    end else if (!stall) begin
      b   = bus.alu_imm_s3 ? bus.sign_ext_imm_s3 : bus.r2_data_s3;
      res = ref_alu(int'(bus.alu_op_s3), bus.r1_data_s3, b, bus.r2_data_s3, int'(bus.shamt_s3));
      sc  = bus.check_link_s3;
      ok  = sc && m_lv && (m_la == res[31:2]);
      ll  = !sc && bus.sel_mem_s3 && !bus.load_link_s3;
      st  = !sc && !bus.mem_rw_s3;
      m_rw = bus.rw_s3; m_sel_mem = bus.sel_mem_s3; m_atomic = bus.atomic_s3;
      m_halt = bus.halt_s3; m_sc_ok = ok;
      m_mem_rw = (sc && !ok) ? 1'b1 : bus.mem_rw_s3;
      m_be = bus.byte_en_s3; m_res = res; m_sd = bus.r2_data_s3; m_wa = bus.waddr_s3;
      m_dp_ok = 1;
      if (sc) m_lv = 0;
      else if (ll) begin m_lv = 1; m_la = res[31:2]; end
      else if (st && m_la == res[31:2]) m_lv = 0;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check(bus.rw_s4, m_rw, "rw_s4");
    check(bus.mem_rw_s4, m_mem_rw, "mem_rw_s4");
    check(bus.sel_mem_s4, m_sel_mem, "sel_mem_s4");
    check(bus.atomic_s4, m_atomic, "atomic_s4");
    check(bus.halt_s4, m_halt, "halt_s4");
    check(bus.sc_ok_s4, m_sc_ok, "sc_ok_s4");
    check(bus.link_valid, m_lv, "link_valid");
    if (m_dp_ok) begin
      check(bus.alu_result_s4, m_res, "alu_result_s4");
      check(bus.store_data_s4, m_sd, "store_data_s4");
      check(bus.waddr_s4, m_wa, "waddr_s4");
      check(bus.byte_en_s4, m_be, "byte_en_s4");
    end
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; flush = 0;
    bus.atomic_s3 = 0; bus.sel_mem_s3 = 0; bus.check_link_s3 = 0; bus.mem_rw_s3 = 1;
    bus.rw_s3 = 1; bus.load_link_s3 = 1; bus.alu_imm_s3 = 0; bus.halt_s3 = 0;
    bus.waddr_s3 = 5'd0; bus.r1_data_s3 = 0; bus.r2_data_s3 = 0; bus.sign_ext_imm_s3 = 0;
    bus.shamt_s3 = 0; bus.alu_op_s3 = 4'h0; bus.byte_en_s3 = 4'hF;
  endtask

  task automatic mem_op(input int kind, input logic [31:0] addr);
    // kind: 0 LL, 1 SC, 2 ordinary store
    idle_inputs();
    bus.r1_data_s3 = addr; bus.alu_imm_s3 = 1; bus.sign_ext_imm_s3 = 0;
    bus.r2_data_s3 = 32'hCAFE_0000 | addr; bus.waddr_s3 = 5'd9;
    case (kind)
      0: begin bus.sel_mem_s3 = 1; bus.load_link_s3 = 0; bus.rw_s3 = 0; bus.atomic_s3 = 1; end
      1: begin bus.check_link_s3 = 1; bus.mem_rw_s3 = 0; bus.rw_s3 = 0; bus.atomic_s3 = 1; end
      default: bus.mem_rw_s3 = 0;
    endcase
  endtask

  task automatic alu_op(input logic [3:0] op, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [4:0] sh);
    idle_inputs();
    bus.alu_op_s3 = op; bus.r1_data_s3 = r1; bus.r2_data_s3 = r2; bus.shamt_s3 = sh;
    bus.rw_s3 = 0; bus.waddr_s3 = 5'd3;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    step();
    step();
    check(bus.rw_s4, 1, "rst rw_s4");
    check(bus.mem_rw_s4, 1, "rst mem_rw_s4");
    check(bus.byte_en_s4, 4'hF, "rst byte_en_s4");
    check(bus.alu_result_s4, 0, "rst alu_result_s4");
    check(bus.link_valid, 0, "rst link_valid");
    rst = 0;

    alu_op(4'h0, 32'h8000_0000, 1, 0); step(); check(bus.alu_result_s4, 32'h8000_0001, "ADD");
    alu_op(4'h1, 32'h8000_0000, 1, 0); step(); check(bus.alu_result_s4, 32'h7FFF_FFFF, "SUB");
    alu_op(4'h6, 32'h8000_0000, 1, 0); step(); check(bus.alu_result_s4, 1, "SLT");
    alu_op(4'h7, 32'h8000_0000, 1, 0); step(); check(bus.alu_result_s4, 0, "SLTU");
    alu_op(4'hA, 32'h8000_0000, 32'hF000_0000, 4); step();
    check(bus.alu_result_s4, 32'hFF00_0000, "SRA");
    alu_op(4'hE, 32'h8000_0000, 1, 0); step(); check(bus.alu_result_s4, 0, "op E");
    for (int op = 2; op <= 15; op++) begin
      alu_op(op[3:0], 32'h8000_00F0, 32'h0000_1234, 5'd3); step();
    end

    alu_op(4'h0, 32'h100, 0, 0);
    bus.alu_imm_s3 = 1; bus.sign_ext_imm_s3 = 32'hFFFF_FFFC; step();
    check(bus.alu_result_s4, 32'h0000_00FC, "imm ADD");

    mem_op(0, 32'h40); step(); check(bus.link_valid, 1, "LL sets link");
    mem_op(1, 32'h40); step();
    check(bus.sc_ok_s4, 1, "SC ok"); check(bus.mem_rw_s4, 0, "SC writes");
    check(bus.link_valid, 0, "SC clears link");
    mem_op(1, 32'h40); step();
    check(bus.sc_ok_s4, 0, "2nd SC fails"); check(bus.mem_rw_s4, 1, "2nd SC no write");

    mem_op(0, 32'h40); step();
    mem_op(2, 32'h44); step(); check(bus.link_valid, 1, "store other keeps link");
    mem_op(2, 32'h40); step(); check(bus.link_valid, 0, "store same clears link");
    mem_op(1, 32'h40); step(); check(bus.sc_ok_s4, 0, "SC after store fails");

    alu_op(4'h0, 5, 7, 0); step(); check(bus.alu_result_s4, 12, "pre-stall");
    for (int i = 0; i < 3; i++) begin
      alu_op(4'h3, $urandom, $urandom, 5'd0); bus.halt_s3 = 1; stall = 1; step();
      check(bus.alu_result_s4, 12, "stall hold result");
      check(bus.halt_s4, 0, "stall hold halt");
    end
    alu_op(4'h0, 1, 1, 0); stall = 1; flush = 1; step();
    check(bus.rw_s4, 1, "flush rw_s4"); check(bus.mem_rw_s4, 1, "flush mem_rw_s4");
    mem_op(0, 32'h40); flush = 1; step(); check(bus.link_valid, 0, "LL under flush");

    mem_op(0, 32'h80); step(); check(bus.link_valid, 1, "LL before rst");
    mem_op(0, 32'h80); rst = 1; step();
    check(bus.link_valid, 0, "rst drops link"); check(bus.alu_result_s4, 0, "rst result");
    check(bus.rw_s4, 1, "rst rw"); check(bus.sel_mem_s4, 0, "rst sel_mem");
    mem_op(1, 32'h80); step(); check(bus.sc_ok_s4, 0, "SC after rst fails");

    for (int i = 0; i < 400; i++) begin
      logic [31:0] addrs [4];
      addrs[0] = 32'h40; addrs[1] = 32'h44; addrs[2] = 32'h80; addrs[3] = $urandom;
      idle_inputs();
      bus.atomic_s3 = 1'($urandom); bus.sel_mem_s3 = 1'($urandom);
      bus.check_link_s3 = ($urandom_range(0, 3) == 0); bus.mem_rw_s3 = 1'($urandom);
      bus.rw_s3 = 1'($urandom); bus.load_link_s3 = 1'($urandom); bus.halt_s3 = ($urandom_range(0, 7) == 0);
      bus.waddr_s3 = 5'($urandom); bus.r2_data_s3 = $urandom; bus.shamt_s3 = 5'($urandom);
      bus.byte_en_s3 = 4'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        bus.alu_op_s3 = 4'h0; bus.r1_data_s3 = addrs[$urandom_range(0, 3)];
        bus.alu_imm_s3 = 1; bus.sign_ext_imm_s3 = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'd4;
      end else begin
        bus.alu_op_s3 = 4'($urandom); bus.r1_data_s3 = $urandom;
        bus.alu_imm_s3 = 1'($urandom); bus.sign_ext_imm_s3 = $urandom;
      end
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
